pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next PC from sequential, relative,
// register and return targets, and keeps a circular return-address stack.
module pc_sequencer #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic             BranchReg,
    input  logic             Link,
    input  logic             Ret,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic             Taken,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasUnderflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == DEPTH_C) ? c : c + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_uf;

    logic signed [WIDTH-1:0] w_off;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_rel;
    logic             w_pop_ok;
    logic             w_rel_sel;
    logic [PTR_W-1:0] w_ptr_pop;
    logic [CNT_W-1:0] w_cnt_pop;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_off     = $signed(SignExtImm) <<< 2;
        w_seq     = r_pc + WIDTH'(4);
        w_rel     = r_pc + $unsigned(w_off);
        w_pop_ok  = Ret && (r_count != '0);
        w_rel_sel = Uncondbranch || (Branch && ALUZero);
        Taken     = Ret || BranchReg || w_rel_sel;

        NextPC = w_seq;
        if (Ret)            NextPC = w_pop_ok ? r_ras[r_top] : RegTarget;
        else if (BranchReg) NextPC = RegTarget;
        else if (w_rel_sel) NextPC = w_rel;

        // Pop is applied first, then the push lands on top of whatever remains.
        w_ptr_pop = w_pop_ok ? r_top - PTR_W'(1) : r_top;
        w_cnt_pop = w_pop_ok ? r_count - CNT_W'(1) : r_count;
        w_ptr_nxt = Link ? w_ptr_pop + PTR_W'(1) : w_ptr_pop;
        w_cnt_nxt = Link ? sat_inc(w_cnt_pop) : w_cnt_pop;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc    <= RESET_VEC;
            r_top   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_uf <= 1'b0;
            if (!Stall) begin
                r_pc    <= NextPC;
                r_top   <= w_ptr_nxt;
                r_count <= w_cnt_nxt;
                r_empty <= (w_cnt_nxt == '0);
                r_full  <= (w_cnt_nxt == DEPTH_C);
                r_uf    <= Ret && (r_count == '0);
            end
        end
    end

    // Entry storage is never cleared; the count keeps stale entries unreadable.
    always_ff @(posedge CLK) begin
        if (!Reset && !Stall && Link)
            r_ras[w_ptr_nxt] <= w_seq;
    end

    assign CurrentPC    = r_pc;
    assign RasEmpty     = r_empty;
    assign RasFull      = r_full;
    assign RasUnderflow = r_uf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branches, return stack, stall, wrap.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset, Stall, Branch, ALUZero, Uncondbranch, BranchReg, Link, Ret;
    logic [63:0] SignExtImm, RegTarget;
    logic [63:0] CurrentPC, NextPC;
    logic        Taken, RasEmpty, RasFull, RasUnderflow;

    int n_chk  = 0;
    int n_pass = 0;

    pc_sequencer #(.WIDTH(64), .RESET_VEC(64'h0), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch), .ALUZero(ALUZero),
        .Uncondbranch(Uncondbranch), .BranchReg(BranchReg), .Link(Link), .Ret(Ret),
        .SignExtImm(SignExtImm), .RegTarget(RegTarget), .CurrentPC(CurrentPC),
        .NextPC(NextPC), .Taken(Taken), .RasEmpty(RasEmpty), .RasFull(RasFull),
        .RasUnderflow(RasUnderflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clr();
        Reset = 0; Stall = 0; Branch = 0; ALUZero = 0; Uncondbranch = 0;
        BranchReg = 0; Link = 0; Ret = 0; SignExtImm = '0; RegTarget = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clr();
        // Reset overrides stall and control inputs
        Reset = 1; Stall = 1; Uncondbranch = 1; Link = 1; SignExtImm = 64'd4;
        tick();
        tick();
        clr();
        settle();
        chk("rst_pc", CurrentPC, 64'h0);
        chk("rst_empty", RasEmpty, 1);
        chk("rst_full", RasFull, 0);
        chk("rst_uf", RasUnderflow, 0);
        chk("rst_taken", Taken, 0);
        chk("rst_next", NextPC, 64'h4);

        tick(); chk("idle_pc1", CurrentPC, 64'h4);
        tick(); chk("idle_pc2", CurrentPC, 64'h8);
        tick(); chk("idle_pc3", CurrentPC, 64'hC);
        chk("idle_taken", Taken, 0);
        chk("idle_empty", RasEmpty, 1);

        // Register branch to 0x100, then conditional branch taken / not taken
        BranchReg = 1; RegTarget = 64'h100; settle();
        chk("br_next", NextPC, 64'h100);
        chk("br_taken", Taken, 1);
        tick(); clr();
        chk("br_pc", CurrentPC, 64'h100);
        Branch = 1; ALUZero = 1; SignExtImm = -64'sd4; settle();
        chk("cbz_next", NextPC, 64'hF0);
        chk("cbz_taken", Taken, 1);
        ALUZero = 0; settle();
        chk("cbz_nt_next", NextPC, 64'h104);
        chk("cbz_nt_taken", Taken, 0);
        clr();

        // Five calls: 0x10 -> 0x20 -> ... -> 0x60, last one overwrites oldest
        BranchReg = 1; RegTarget = 64'h10; tick(); clr();
        chk("call_start", CurrentPC, 64'h10);
        Uncondbranch = 1; Link = 1; SignExtImm = 64'd4;
        tick(); tick(); tick();
        chk("call3_full", RasFull, 0);
        chk("call3_empty", RasEmpty, 0);
        tick();
        chk("call4_full", RasFull, 1);
        chk("call4_pc", CurrentPC, 64'h50);
        tick(); clr();
        chk("call5_pc", CurrentPC, 64'h60);
        chk("call5_full", RasFull, 1);

        Ret = 1; settle();
        chk("ret1_next", NextPC, 64'h54);
        chk("ret1_taken", Taken, 1);
        tick();
        chk("ret1_pc", CurrentPC, 64'h54);
        chk("ret1_full", RasFull, 0);
        chk("ret1_uf", RasUnderflow, 0);
        chk("ret2_next", NextPC, 64'h44);
        tick();
        chk("ret3_next", NextPC, 64'h34);
        tick();
        chk("ret4_next", NextPC, 64'h24);
        tick();
        chk("ret4_pc", CurrentPC, 64'h24);
        chk("ret4_empty", RasEmpty, 1);
        RegTarget = 64'h900; settle();
        chk("ret5_next", NextPC, 64'h900);
        tick(); clr();
        chk("ret5_pc", CurrentPC, 64'h900);
        chk("ret5_uf", RasUnderflow, 1);
        tick();
        chk("uf_pulse_end", RasUnderflow, 0);
        chk("uf_pc", CurrentPC, 64'h904);
        chk("uf_empty", RasEmpty, 1);

        // Stall holds PC and RAS; redirect lands on first unstalled edge
        Stall = 1; Uncondbranch = 1; Link = 1; SignExtImm = 64'd4;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_taken", Taken, 1);
            tick();
            chk("stall_pc", CurrentPC, 64'h904);
            chk("stall_empty", RasEmpty, 1);
        end
        Stall = 0; Link = 0; tick(); clr();
        chk("unstall_pc", CurrentPC, 64'h914);
        chk("unstall_empty", RasEmpty, 1);
        Stall = 1; Ret = 1; RegTarget = 64'h300; tick(); clr();
        chk("stall_ret_uf", RasUnderflow, 0);
        chk("stall_ret_pc", CurrentPC, 64'h914);

        // Wrap past the top of the address space
        BranchReg = 1; RegTarget = 64'hFFFF_FFFF_FFFF_FFFC; tick(); clr();
        settle();
        chk("wrap_next", NextPC, 64'h0);
        tick();
        chk("wrap_pc", CurrentPC, 64'h0);

        // Fill with sequential links (pushes 4, 8, C, 10), then Link+Ret when full
        Link = 1; tick(); tick(); tick(); tick(); clr();
        chk("fill_pc", CurrentPC, 64'h10);
        chk("fill_full", RasFull, 1);
        Link = 1; Ret = 1; settle();
        chk("lr_next", NextPC, 64'h10);
        tick(); clr();
        chk("lr_pc", CurrentPC, 64'h10);
        chk("lr_full", RasFull, 1);
        chk("lr_uf", RasUnderflow, 0);
        Ret = 1; settle();
        chk("lr_top", NextPC, 64'h14);

        // Reset while full and stalled
        Reset = 1; Stall = 1; tick(); clr();
        chk("mid_rst_pc", CurrentPC, 64'h0);
        chk("mid_rst_empty", RasEmpty, 1);
        chk("mid_rst_full", RasFull, 0);

        // Link+Ret on empty stack: underflow and count becomes 1
        Link = 1; Ret = 1; RegTarget = 64'h200; settle();
        chk("lr0_next", NextPC, 64'h200);
        tick(); clr();
        chk("lr0_uf", RasUnderflow, 1);
        chk("lr0_empty", RasEmpty, 0);
        chk("lr0_pc", CurrentPC, 64'h200);
        Ret = 1; settle();
        chk("lr0_top", NextPC, 64'h4);
        tick(); clr();
        chk("lr0_pop_empty", RasEmpty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
